// File: rtl/sr_ff_monitor.sv
// Reference-model monitor for an SR flip-flop: flags wrong or non-complementary q/qbar.
// Optional first-failure capture is built when SRMON_FIRST_FAIL_EN is defined.
module sr_ff_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             s_in,
  input  logic             r_in,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             exp_q,
  output logic             exp_valid,
  output logic [1:0]       mon_state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             forbidden_seen,
  output logic [31:0]      fail_cycle,
  output logic             fail_valid
);

  typedef enum logic [1:0] {
    StUnknown   = 2'b00,
    StKnown     = 2'b01,
    StForbidden = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               model_q_q, model_q_d;
  logic [LATENCY-1:0] dl_q_q, dl_v_q;
  logic               err_pulse_q, forbidden_q;
  logic [CNT_W-1:0]   err_count_q;
  logic               check_fail, cmd_forbidden;

  always_comb begin
    state_d       = state_q;
    model_q_d     = model_q_q;
    cmd_forbidden = 1'b0;
    case ({s_in, r_in})
      2'b10: begin
        state_d   = StKnown;
        model_q_d = 1'b1;
      end
      2'b01: begin
        state_d   = StKnown;
        model_q_d = 1'b0;
      end
      2'b11: begin
        state_d       = StForbidden;
        cmd_forbidden = 1'b1;
      end
      default: ;
    endcase
  end

  // Only the oldest delay stage is compared; an invalid entry suppresses the check.
  assign check_fail = dl_v_q[LATENCY-1] &&
                      ((q_in != dl_q_q[LATENCY-1]) || (qbar_in == q_in));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StUnknown;
      model_q_q   <= 1'b0;
      dl_q_q      <= '0;
      dl_v_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      forbidden_q <= 1'b0;
    end else if (enable) begin
      state_q   <= state_d;
      model_q_q <= model_q_d;
      for (int i = LATENCY - 1; i > 0; i--) begin
        dl_q_q[i] <= dl_q_q[i-1];
        dl_v_q[i] <= dl_v_q[i-1];
      end
      dl_q_q[0]   <= model_q_d;
      dl_v_q[0]   <= (state_d == StKnown);
      err_pulse_q <= check_fail;
      if (clear) begin
        err_count_q <= '0;
      end else if (check_fail && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + CNT_W'(1);
      end
      // A new forbidden command outranks clear on the same edge.
      if (cmd_forbidden) begin
        forbidden_q <= 1'b1;
      end else if (clear) begin
        forbidden_q <= 1'b0;
      end
    end
  end

  assign exp_q          = model_q_q;
  assign exp_valid      = (state_q == StKnown);
  assign mon_state      = state_q;
  assign err_pulse      = err_pulse_q;
  assign err_count      = err_count_q;
  assign forbidden_seen = forbidden_q;

`ifdef SRMON_FIRST_FAIL_EN
  logic [31:0] edge_cnt_q, fail_cycle_q;
  logic        fail_valid_q;

  // The first enabled edge after reset is edge 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt_q   <= '0;
      fail_cycle_q <= '0;
      fail_valid_q <= 1'b0;
    end else if (enable) begin
      edge_cnt_q <= edge_cnt_q + 32'd1;
      if (clear) begin
        fail_cycle_q <= '0;
        fail_valid_q <= 1'b0;
      end else if (check_fail && !fail_valid_q) begin
        fail_cycle_q <= edge_cnt_q + 32'd1;
        fail_valid_q <= 1'b1;
      end
    end
  end

  assign fail_cycle = fail_cycle_q;
  assign fail_valid = fail_valid_q;
`else
  assign fail_cycle = '0;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed bench for sr_ff_monitor (LATENCY=1, CNT_W=8).
module tb_sr_ff_monitor;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        s_in = 1'b0;
  logic        r_in = 1'b0;
  logic        q_in = 1'b0;
  logic        qbar_in = 1'b1;
  logic        exp_q, exp_valid, err_pulse, forbidden_seen, fail_valid;
  logic [1:0]  mon_state;
  logic [7:0]  err_count;
  logic [31:0] fail_cycle;

  int checks = 0;
  int errors = 0;

  sr_ff_monitor #(.CNT_W(8), .LATENCY(1)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .clear          (clear),
    .s_in           (s_in),
    .r_in           (r_in),
    .q_in           (q_in),
    .qbar_in        (qbar_in),
    .exp_q          (exp_q),
    .exp_valid      (exp_valid),
    .mon_state      (mon_state),
    .err_pulse      (err_pulse),
    .err_count      (err_count),
    .forbidden_seen (forbidden_seen),
    .fail_cycle     (fail_cycle),
    .fail_valid     (fail_valid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic q, input logic qb);
    s_in = s; r_in = r; q_in = q; qbar_in = qb;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 1);
    tick(); tick();
    checks++; if (mon_state !== 2'b00) begin errors++; $display("FAIL rst_state got %0h exp 0", mon_state); end
    checks++; if (exp_q !== 1'b0 || exp_valid !== 1'b0) begin errors++; $display("FAIL rst_exp got %0b%0b exp 00", exp_q, exp_valid); end
    checks++; if (err_count !== 8'd0 || err_pulse !== 1'b0 || forbidden_seen !== 1'b0) begin
      errors++; $display("FAIL rst_err got cnt %0d pulse %0b fs %0b exp 0 0 0", err_count, err_pulse, forbidden_seen);
    end
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (mon_state !== 2'b00 || err_count !== 8'd0 || err_pulse !== 1'b0) begin
        errors++; $display("FAIL idle_%0d got st %0h cnt %0d pulse %0b exp 0 0 0", i, mon_state, err_count, err_pulse);
      end
    end
  endtask

  task automatic test_known();
    drive(1, 0, 0, 1); tick();
    checks++; if (exp_q !== 1'b1 || mon_state !== 2'b01 || exp_valid !== 1'b1) begin
      errors++; $display("FAIL set_model got q %0b st %0h v %0b exp 1 1 1", exp_q, mon_state, exp_valid);
    end
    drive(0, 0, 1, 0); tick();
    checks++; if (err_count !== 8'd0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL set_check got cnt %0d pulse %0b exp 0 0", err_count, err_pulse);
    end
    drive(0, 1, 1, 0); tick();
    checks++; if (exp_q !== 1'b0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_cmd got q %0b pulse %0b exp 0 0", exp_q, err_pulse);
    end
    drive(0, 0, 1, 0); tick();
    checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL stuck_q got pulse %0b cnt %0d exp 1 1", err_pulse, err_count);
    end
    drive(0, 0, 0, 1); tick();
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd1) begin
      errors++; $display("FAIL pulse_once got pulse %0b cnt %0d exp 0 1", err_pulse, err_count);
    end
  endtask

  task automatic test_forbidden();
    drive(1, 1, 0, 1); tick();
    checks++; if (mon_state !== 2'b10 || forbidden_seen !== 1'b1 || exp_valid !== 1'b0 || exp_q !== 1'b0) begin
      errors++; $display("FAIL forb_enter got st %0h fs %0b v %0b q %0b exp 2 1 0 0", mon_state, forbidden_seen, exp_valid, exp_q);
    end
    drive(0, 0, 0, 0); tick(); tick();
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd1 || mon_state !== 2'b10) begin
      errors++; $display("FAIL forb_nochk got pulse %0b cnt %0d st %0h exp 0 1 2", err_pulse, err_count, mon_state);
    end
    drive(0, 1, 0, 0); tick();
    checks++; if (mon_state !== 2'b01 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL forb_exit got st %0h pulse %0b exp 1 0", mon_state, err_pulse);
    end
    drive(0, 0, 0, 1); tick();
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd1) begin
      errors++; $display("FAIL forb_after got pulse %0b cnt %0d exp 0 1", err_pulse, err_count);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; drive(0, 0, 0, 1); tick();
    checks++; if (err_count !== 8'd0 || forbidden_seen !== 1'b0 || mon_state !== 2'b01 || exp_q !== 1'b0) begin
      errors++; $display("FAIL clear got cnt %0d fs %0b st %0h q %0b exp 0 0 1 0", err_count, forbidden_seen, mon_state, exp_q);
    end
    drive(1, 1, 0, 1); tick();
    checks++; if (forbidden_seen !== 1'b1 || err_count !== 8'd0) begin
      errors++; $display("FAIL clear_vs_11 got fs %0b cnt %0d exp 1 0", forbidden_seen, err_count);
    end
    clear = 1'b0;
    drive(0, 1, 0, 1); tick();
    drive(0, 0, 0, 1); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (forbidden_seen !== 1'b0 || mon_state !== 2'b01 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL clear_fs got fs %0b st %0h pulse %0b exp 0 1 0", forbidden_seen, mon_state, err_pulse);
    end
  endtask

  task automatic test_enable_hold();
    enable = 1'b0;
    drive(1, 0, 1, 1);
    repeat (3) tick();
    checks++; if (mon_state !== 2'b01 || exp_q !== 1'b0 || err_count !== 8'd0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL hold got st %0h q %0b cnt %0d pulse %0b exp 1 0 0 0", mon_state, exp_q, err_count, err_pulse);
    end
    enable = 1'b1;
    drive(0, 0, 0, 1); tick();
    checks++; if (err_pulse !== 1'b0 || exp_q !== 1'b0) begin
      errors++; $display("FAIL hold_resume got pulse %0b q %0b exp 0 0", err_pulse, exp_q);
    end
  endtask

  task automatic test_saturation();
    drive(0, 0, 1, 1);
    repeat (254) tick();
    checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", err_count); end
    repeat (46) tick();
    checks++; if (err_count !== 8'd255 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL sat_255 got cnt %0d pulse %0b exp 255 1", err_count, err_pulse);
    end
`ifndef SRMON_FIRST_FAIL_EN
    checks++; if (fail_valid !== 1'b0 || fail_cycle !== 32'd0) begin
      errors++; $display("FAIL ff_off got v %0b cyc %0d exp 0 0", fail_valid, fail_cycle);
    end
`endif
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (err_count !== 8'd0 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL clear_fail got cnt %0d pulse %0b exp 0 1", err_count, err_pulse);
    end
    drive(0, 0, 0, 1); tick();
    checks++; if (err_count !== 8'd0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL sat_recover got cnt %0d pulse %0b exp 0 0", err_count, err_pulse);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 1, 0); tick();
    drive(1, 1, 1, 0); tick();
    checks++; if (err_count !== 8'd2 || forbidden_seen !== 1'b1 || mon_state !== 2'b10) begin
      errors++; $display("FAIL pre_rst got cnt %0d fs %0b st %0h exp 2 1 2", err_count, forbidden_seen, mon_state);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (err_count !== 8'd0 || forbidden_seen !== 1'b0 || mon_state !== 2'b00 || err_pulse !== 1'b0 || exp_q !== 1'b0) begin
      errors++; $display("FAIL async_rst got cnt %0d fs %0b st %0h pulse %0b q %0b exp 0 0 0 0 0",
                         err_count, forbidden_seen, mon_state, err_pulse, exp_q);
    end
    tick();
    @(negedge clock) reset_n = 1'b1;
    drive(0, 0, 1, 1); tick();
    checks++; if (err_count !== 8'd0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL post_rst_nochk got cnt %0d pulse %0b exp 0 0", err_count, err_pulse);
    end
    drive(1, 0, 1, 1); tick();
    checks++; if (err_pulse !== 1'b0 || mon_state !== 2'b01 || exp_q !== 1'b1) begin
      errors++; $display("FAIL post_rst_cmd got pulse %0b st %0h q %0b exp 0 1 1", err_pulse, mon_state, exp_q);
    end
    drive(0, 0, 0, 1); tick();
    checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL post_rst_chk got pulse %0b cnt %0d exp 1 1", err_pulse, err_count);
    end
  endtask

  task automatic test_first_fail();
    reset_n = 1'b0; tick();
    @(negedge clock) reset_n = 1'b1;
    drive(1, 0, 0, 1); tick();
    drive(0, 0, 1, 0);
    repeat (5) tick();
    checks++; if (fail_valid !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL ff_pre got v %0b cnt %0d exp 0 0", fail_valid, err_count);
    end
    q_in = 1'b0; qbar_in = 1'b1; tick();
    q_in = 1'b1; qbar_in = 1'b0; tick();
    q_in = 1'b0; qbar_in = 1'b1; tick();
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL ff_cnt got %0d exp 2", err_count); end
`ifdef SRMON_FIRST_FAIL_EN
    checks++; if (fail_valid !== 1'b1 || fail_cycle !== 32'd7) begin
      errors++; $display("FAIL ff_capture got v %0b cyc %0d exp 1 7", fail_valid, fail_cycle);
    end
`else
    checks++; if (fail_valid !== 1'b0 || fail_cycle !== 32'd0) begin
      errors++; $display("FAIL ff_absent got v %0b cyc %0d exp 0 0", fail_valid, fail_cycle);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_known();
    test_forbidden();
    test_clear();
    test_enable_hold();
    test_saturation();
    test_async_reset();
    test_first_fail();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
